// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer: collects decimated samples into FRAME_LEN frames and streams them out over valid/ready.
// Optional saturating dropped-sample counter on drop_count_out when AUDIO_FRAME_DROP_COUNT_EN is defined.
module audio_frame_buffer #(
    parameter int FRAME_LEN  = 256,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    output logic [DATA_WIDTH-1:0] frame_data_out,
    output logic                  frame_valid_out,
    output logic                  frame_last_out,
    input  logic                  frame_ready_in,
    output logic                  overflow_out
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count_out
`endif
);

    localparam int              IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [1:0] BANK_EMPTY    = 2'd0;
    localparam logic [1:0] BANK_FILLING  = 2'd1;
    localparam logic [1:0] BANK_FULL     = 2'd2;
    localparam logic [1:0] BANK_DRAINING = 2'd3;

    localparam logic [1:0] RD_IDLE   = 2'd0;
    localparam logic [1:0] RD_FETCH  = 2'd1;
    localparam logic [1:0] RD_STREAM = 2'd2;

    logic [DATA_WIDTH-1:0] mem_r [0:2*FRAME_LEN-1];
    logic [1:0]            bank_state_r [2];

    logic                  wr_bank_r;
    logic [IDX_W-1:0]      wr_idx_r;
    logic                  stalled_r;
    logic [1:0]            rd_state_r;
    logic                  rd_bank_r;
    logic [IDX_W-1:0]      rd_idx_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  valid_r;
    logic                  last_r;
    logic                  overflow_r;

    logic                  handshake_s;
    logic                  release_s;
    logic                  wr_sel_s;
    logic                  wr_other_s;
    logic                  wr_en_s;
    logic                  wr_done_s;
    logic                  drop_s;
    logic                  other_free_s;
    logic                  claim_s;
    logic                  claim_bank_s;
    logic                  rd_en_s;
    logic                  nb_wr_s;
    logic                  nb_rd_s;

    assign handshake_s = valid_r && frame_ready_in;
    assign release_s   = handshake_s && last_r;
    assign nb_wr_s     = ~wr_bank_r;
    assign nb_rd_s     = ~rd_bank_r;

    // Write steering: a stall clears on the release edge and that cycle's sample goes to the freed bank
    always_comb begin
        wr_sel_s     = wr_bank_r;
        wr_en_s      = 1'b0;
        drop_s       = 1'b0;
        if (stalled_r) begin
            if (release_s) begin
                wr_sel_s = nb_wr_s;
                wr_en_s  = sample_valid_in;
            end else begin
                drop_s   = sample_valid_in;
            end
        end else begin
            wr_en_s = sample_valid_in;
        end
        wr_other_s   = ~wr_sel_s;
        wr_done_s    = wr_en_s && (wr_idx_r == LAST_IDX);
        other_free_s = (bank_state_r[wr_other_s] == BANK_EMPTY) ||
                       (release_s && (rd_bank_r == wr_other_s));
    end

    // Read-side decisions: which bank to claim and when to issue a BRAM read
    always_comb begin
        claim_s      = 1'b0;
        claim_bank_s = rd_bank_r;
        rd_en_s      = 1'b0;
        case (rd_state_r)
            RD_IDLE: begin
                // When both banks hold frames, the one the writer left behind is the older
                if (bank_state_r[nb_wr_s] == BANK_FULL) begin
                    claim_s      = 1'b1;
                    claim_bank_s = nb_wr_s;
                end else if (bank_state_r[wr_bank_r] == BANK_FULL) begin
                    claim_s      = 1'b1;
                    claim_bank_s = wr_bank_r;
                end else begin
                    claim_s      = 1'b0;
                end
            end
            RD_FETCH: begin
                rd_en_s = 1'b1;
            end
            RD_STREAM: begin
                if (handshake_s) begin
                    if (last_r) begin
                        if (bank_state_r[nb_rd_s] == BANK_FULL) begin
                            claim_s      = 1'b1;
                            claim_bank_s = nb_rd_s;
                        end else begin
                            claim_s      = 1'b0;
                        end
                    end else begin
                        rd_en_s = 1'b1;
                    end
                end else begin
                    rd_en_s = 1'b0;
                end
            end
            default: begin
                claim_s = 1'b0;
            end
        endcase
    end

    // Sample storage write port
    always_ff @(posedge clk_in) begin
        if (wr_en_s && !rst_in) begin
            mem_r[{wr_sel_s, wr_idx_r}] <= sample_in;
        end
    end

    // Sample storage read port; this register is the output data register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en_s) begin
            rdata_r <= mem_r[{rd_bank_r, rd_idx_r}];
        end
    end

    // Per-bank lifecycle; a write on a bank released this cycle takes precedence
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bank_state_r[0] <= BANK_EMPTY;
            bank_state_r[1] <= BANK_EMPTY;
        end else begin
            if (claim_s) begin
                bank_state_r[claim_bank_s] <= BANK_DRAINING;
            end
            if (release_s) begin
                bank_state_r[rd_bank_r] <= BANK_EMPTY;
            end
            if (wr_en_s) begin
                bank_state_r[wr_sel_s] <= wr_done_s ? BANK_FULL : BANK_FILLING;
            end
        end
    end

    // Write pointer, bank select and stall flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_bank_r <= 1'b0;
            wr_idx_r  <= IDX_W'(0);
            stalled_r <= 1'b0;
        end else if (wr_en_s) begin
            if (wr_done_s) begin
                wr_idx_r  <= IDX_W'(0);
                wr_bank_r <= other_free_s ? wr_other_s : wr_sel_s;
                stalled_r <= !other_free_s;
            end else begin
                wr_idx_r  <= wr_idx_r + IDX_W'(1);
                wr_bank_r <= wr_sel_s;
                stalled_r <= 1'b0;
            end
        end else if (stalled_r && release_s) begin
            wr_bank_r <= nb_wr_s;
            stalled_r <= 1'b0;
        end
    end

    // Read FSM and output valid/last registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_state_r <= RD_IDLE;
            rd_bank_r  <= 1'b0;
            rd_idx_r   <= IDX_W'(0);
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            case (rd_state_r)
                RD_IDLE: begin
                    if (claim_s) begin
                        rd_state_r <= RD_FETCH;
                        rd_bank_r  <= claim_bank_s;
                        rd_idx_r   <= IDX_W'(0);
                    end
                end
                RD_FETCH: begin
                    rd_state_r <= RD_STREAM;
                    valid_r    <= 1'b1;
                    last_r     <= 1'b0;
                    rd_idx_r   <= IDX_W'(1);
                end
                RD_STREAM: begin
                    if (handshake_s) begin
                        if (last_r) begin
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            if (claim_s) begin
                                rd_state_r <= RD_FETCH;
                                rd_bank_r  <= claim_bank_s;
                                rd_idx_r   <= IDX_W'(0);
                            end else begin
                                rd_state_r <= RD_IDLE;
                            end
                        end else begin
                            last_r   <= (rd_idx_r == LAST_IDX);
                            rd_idx_r <= rd_idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    rd_state_r <= RD_IDLE;
                    valid_r    <= 1'b0;
                    last_r     <= 1'b0;
                end
            endcase
        end
    end

    // Dropped-sample pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= drop_s;
        end
    end

`ifdef AUDIO_FRAME_DROP_COUNT_EN
    logic [15:0] drop_count_r;

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            drop_count_r <= 16'h0000;
        end else if (overflow_r && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'h0001;
        end
    end

    assign drop_count_out = drop_count_r;
`endif

    assign frame_data_out  = rdata_r;
    assign frame_valid_out = valid_r;
    assign frame_last_out  = last_r;
    assign overflow_out    = overflow_r;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Self-checking bench for audio_frame_buffer (FRAME_LEN=8) against a frame-queue reference model.
module tb_audio_frame_buffer;

    localparam int FL = 8;
    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid_in = 1'b0;
    logic          frame_ready_in = 1'b0;
    logic [DW-1:0] frame_data_out;
    logic          frame_valid_out;
    logic          frame_last_out;
    logic          overflow_out;
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    logic [15:0]   drop_count_out;
`endif

    audio_frame_buffer #(.FRAME_LEN(FL), .DATA_WIDTH(DW)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .frame_data_out  (frame_data_out),
        .frame_valid_out (frame_valid_out),
        .frame_last_out  (frame_last_out),
        .frame_ready_in  (frame_ready_in),
        .overflow_out    (overflow_out)
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        ,
        .drop_count_out  (drop_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: complete frames awaiting consumption, plus the frame being collected
    logic [15:0] out_q[$];
    logic [15:0] part_q[$];
    int          n_frames;
    int          out_idx;
    bit          exp_ovf;
    int          ovf_seen;
    int          drop_model;
    bit          prev_valid;
    bit          prev_rdy;
    logic [15:0] prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        out_q.delete();
        part_q.delete();
        n_frames   = 0;
        out_idx    = 0;
        exp_ovf    = 1'b0;
        drop_model = 0;
        prev_valid = 1'b0;
        prev_rdy   = 1'b0;
    endtask

    // One cycle: check outputs seen now, update the model, drive inputs for the next edge
    task automatic step(input bit sv, input logic [15:0] sd, input bit rdy);
        chk("overflow", 32'(overflow_out), 32'(exp_ovf));
        if (overflow_out) ovf_seen++;
        if (prev_valid && !prev_rdy) begin
            chk("hold_valid", 32'(frame_valid_out), 32'd1);
            chk("hold_data", 32'(frame_data_out), 32'(prev_data));
            chk("hold_last", 32'(frame_last_out), 32'(prev_last));
        end
        if (frame_valid_out) begin
            chk("valid_has_frame", 32'(out_q.size() > 0), 32'd1);
            if (rdy && out_q.size() > 0) begin
                chk("data", 32'(frame_data_out), 32'(out_q[0]));
                chk("last", 32'(frame_last_out), 32'(out_idx == FL - 1));
                void'(out_q.pop_front());
                if (out_idx == FL - 1) begin
                    out_idx = 0;
                    n_frames--;
                end else begin
                    out_idx++;
                end
            end
        end
        prev_valid = frame_valid_out;
        prev_rdy   = rdy;
        prev_data  = frame_data_out;
        prev_last  = frame_last_out;
        exp_ovf    = 1'b0;
        if (sv) begin
            if (part_q.size() > 0 || n_frames < 2) begin
                part_q.push_back(sd);
                if (part_q.size() == FL) begin
                    foreach (part_q[k]) out_q.push_back(part_q[k]);
                    part_q.delete();
                    n_frames++;
                end
            end else begin
                exp_ovf = 1'b1;
                if (drop_model < 65535) drop_model++;
            end
        end
        sample_valid_in = sv;
        sample_in       = sd;
        frame_ready_in  = rdy;
        @(negedge clk_in);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, 32'(frame_data_out), 32'd0);
        chk({tag, "_valid"}, 32'(frame_valid_out), 32'd0);
        chk({tag, "_last"}, 32'(frame_last_out), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_out), 32'd0);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        chk({tag, "_dropcnt"}, 32'(drop_count_out), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        frame_ready_in  = 1'b0;
        repeat (2) @(negedge clk_in);
        check_zero("reset");
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((out_q.size() > 0 || frame_valid_out) && n < bound) begin
            step(1'b0, 16'h0000, 1'b1);
            n++;
        end
        chk("drain_empty", 32'(out_q.size()), 32'd0);
        chk("drain_idle", 32'(frame_valid_out), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        model_reset();
        ovf_seen = 0;
        @(negedge clk_in);

        // Basic frame with latency and back-to-back streaming
        do_reset();
        for (int i = 1; i <= FL; i++) step(1'b1, 16'(i), 1'b1);
        lat = 0;
        while (!frame_valid_out && lat < 20) begin
            step(1'b0, 16'h0000, 1'b1);
            lat++;
        end
        chk("first_valid_latency", 32'(lat), 32'd2);
        for (int i = 0; i < FL; i++) begin
            chk("stream_consecutive", 32'(frame_valid_out), 32'd1);
            step(1'b0, 16'h0000, 1'b1);
        end
        chk("stream_end", 32'(frame_valid_out), 32'd0);

        // Back-pressure with ready 1,0,0,1,0,0...
        do_reset();
        for (int i = 1; i <= FL; i++) step(1'b1, 16'(i), 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 16'h0000, bit'(i % 3 == 0));
        drain(50);

        // Both banks full, third frame's samples dropped
        do_reset();
        ovf_seen = 0;
        for (int i = 1; i <= 3 * FL; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("overflow_pulses", 32'(ovf_seen), 32'd8);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        chk("drop_count_8", 32'(drop_count_out), 32'd8);
`endif
        drain(100);
        for (int i = 0; i < FL; i++) step(1'b1, 16'(16'd500 + 16'(i)), 1'b1);
        drain(50);

        // Continuous input, one sample every 4 cycles, five frames
        do_reset();
        ovf_seen = 0;
        for (int i = 0; i < 5 * FL; i++) begin
            step(1'b1, 16'(16'd1000 + 16'(i)), 1'b1);
            repeat (3) step(1'b0, 16'h0000, 1'b1);
        end
        drain(50);
        chk("continuous_no_overflow", 32'(ovf_seen), 32'd0);

        // Reset while streaming output sample 4
        do_reset();
        for (int i = 1; i <= FL; i++) step(1'b1, 16'(i), 1'b0);
        n = 0;
        while (!(frame_valid_out && frame_data_out == 16'd4) && n < 30) begin
            step(1'b0, 16'h0000, 1'b1);
            n++;
        end
        chk("reached_sample4", 32'(frame_data_out), 32'd4);
        sample_valid_in = 1'b0;
        frame_ready_in  = 1'b1;
        rst_in          = 1'b1;
        @(negedge clk_in);
        check_zero("midstream_reset");
        rst_in = 1'b0;
        model_reset();
        for (int i = 0; i < FL; i++) step(1'b1, 16'(16'd100 + 16'(i)), 1'b1);
        drain(50);

        // Release of bank A on the same edge as bank B's last write
        do_reset();
        ovf_seen = 0;
        for (int i = 0; i < FL; i++) step(1'b1, 16'(16'd200 + 16'(i)), 1'b0);
        for (int i = 0; i < FL - 1; i++) step(1'b1, 16'(16'd300 + 16'(i)), 1'b0);
        n = 0;
        while (!(frame_valid_out && frame_last_out) && n < 40) begin
            step(1'b0, 16'h0000, 1'b1);
            n++;
        end
        chk("bank_a_last_seen", 32'(frame_last_out), 32'd1);
        step(1'b1, 16'(16'd300 + 16'(FL - 1)), 1'b1);
        for (int i = 0; i < FL; i++) step(1'b1, 16'(16'd400 + 16'(i)), 1'b1);
        drain(80);
        chk("boundary_no_overflow", 32'(ovf_seen), 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(bit'($urandom_range(0, 9) < 6), 16'($urandom), bit'($urandom_range(0, 9) < 4));
        end
        drain(2000);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        chk("drop_count_random", 32'(drop_count_out), 32'(drop_model));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
